store_commit_drain: RTL and testbench

- Drains architecturally committed stores to memory; it is the consumer side of the store queue.
- At retirement, up to N committed stores per cycle are written into an internal FIFO, the committed-store buffer (CSB).
- The block issues the buffered stores to the D-side memory port in program order, one at a time, over a valid/ready handshake.
- It reports slot availability back to retire and an empty flag for halt/drain checks.

---
 rtl/store_commit_drain_if.sv | 39 +++
 rtl/store_commit_drain.sv | 184 ++++++++++++++++++
 tb/tb_store_commit_drain.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/store_commit_drain_if.sv
// Store commit drain bus: retire-side commit lanes, status back to retire,
// and the valid/ready write request port towards the D-side memory.
//   commit_valid/addr/data/mask : up to N committed stores per cycle
//   csb_free_slots, csb_empty   : buffer occupancy status
//   mem_req_valid/addr/data/mask, mem_req_ready : memory write handshake
//   drain_done                  : one-cycle pulse per completed write
// slave modport is the drain block; master modport is its environment.
interface store_commit_drain_if #(
    parameter int unsigned N         = 2,
    parameter int unsigned CSB_DEPTH = 8,
    parameter int unsigned ADDR_W    = 32
);
    localparam int unsigned FS_W = $clog2(CSB_DEPTH + 1);

    logic [N-1:0]        commit_valid;
    logic [N*ADDR_W-1:0] commit_addr;
    logic [N*32-1:0]     commit_data;
    logic [N*4-1:0]      commit_mask;
    logic [FS_W-1:0]     csb_free_slots;
    logic                csb_empty;
    logic                mem_req_valid;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [31:0]         mem_req_data;
    logic [3:0]          mem_req_mask;
    logic                mem_req_ready;
    logic                drain_done;

    modport master (
        output commit_valid, commit_addr, commit_data, commit_mask, mem_req_ready,
        input  csb_free_slots, csb_empty, mem_req_valid, mem_req_addr,
        input  mem_req_data, mem_req_mask, drain_done
    );

    modport slave (
        input  commit_valid, commit_addr, commit_data, commit_mask, mem_req_ready,
        output csb_free_slots, csb_empty, mem_req_valid, mem_req_addr,
        output mem_req_data, mem_req_mask, drain_done
    );
endinterface

// File: rtl/store_commit_drain.sv
// Committed-store buffer (CSB) and drain engine. Buffers up to N retired
// stores per cycle in a circular FIFO and issues them in program order, one
// at a time, on the memory write handshake.
// Ports: clock, reset (synchronous, active-high), bus (store_commit_drain_if.slave).
// Optional feature: define STORE_COMMIT_COALESCE_EN to merge a committed lane
// into the youngest buffered entry when it targets the same word.
module store_commit_drain #(
    parameter int unsigned N         = 2,
    parameter int unsigned CSB_DEPTH = 8,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    store_commit_drain_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(CSB_DEPTH);
    localparam int unsigned CNT_W = $clog2(CSB_DEPTH + 1);
    localparam int unsigned WA_W  = ADDR_W - 2;

    typedef struct packed {
        logic [WA_W-1:0] addr;
        logic [31:0]     data;
        logic [3:0]      mask;
    } entry_t;

    typedef enum logic {IDLE, SEND} state_e;

    state_e           state_q, state_d;
    entry_t           ent_q [CSB_DEPTH];
    entry_t           ent_d [CSB_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d, alloc_n;
    entry_t           req_q, req_d;
    logic             req_valid_q, req_valid_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] free_q;
    logic             empty_q;
    logic             pop, load;
    logic [PTR_W-1:0] load_idx;
    logic             unused_addr_lsbs;
`ifdef STORE_COMMIT_COALESCE_EN
    logic             young_ok;
    logic [PTR_W-1:0] young_idx;
`endif

    // Drain FSM: loads the head entry into the output registers and pops it on handshake.
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        req_d       = req_q;
        req_valid_d = req_valid_q;
        done_d      = 1'b0;
        pop         = 1'b0;
        load        = 1'b0;
        load_idx    = head_q;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.mem_req_ready) begin
                    pop    = 1'b1;
                    done_d = 1'b1;
                    head_d = head_q + PTR_W'(1);
                    // Back-to-back issue only from entries present before this edge.
                    if (count_q >= CNT_W'(2)) begin
                        load     = 1'b1;
                        load_idx = head_q + PTR_W'(1);
                    end else begin
                        state_d     = IDLE;
                        req_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            req_valid_d = 1'b1;
            req_d       = ent_q[load_idx];
        end
    end

    // Enqueue valid lanes in lane order at tail (optionally merging into the youngest entry).
    always_comb begin
        entry_t lane_e;
        ent_d   = ent_q;
        tail_d  = tail_q;
        alloc_n = '0;
`ifdef STORE_COMMIT_COALESCE_EN
        young_ok  = (count_q != '0);
        young_idx = tail_q - PTR_W'(1);
`endif
        for (int l = 0; l < int'(N); l++) begin
            lane_e.addr = bus.commit_addr[l*ADDR_W + 2 +: WA_W];
            lane_e.data = bus.commit_data[l*32 +: 32];
            lane_e.mask = bus.commit_mask[l*4 +: 4];
            if (bus.commit_valid[l]) begin
`ifdef STORE_COMMIT_COALESCE_EN
                // An entry sitting in, or entering, the output registers is frozen.
                if (young_ok && (ent_d[young_idx].addr == lane_e.addr) &&
                    !((state_q == SEND && young_idx == head_q) ||
                      (load && young_idx == load_idx))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (lane_e.mask[b]) begin
                            ent_d[young_idx].data[8*b +: 8] = lane_e.data[8*b +: 8];
                        end
                    end
                    ent_d[young_idx].mask = ent_d[young_idx].mask | lane_e.mask;
                end else begin
                    ent_d[tail_d] = lane_e;
                    young_idx     = tail_d;
                    young_ok      = 1'b1;
                    tail_d        = tail_d + PTR_W'(1);
                    alloc_n       = alloc_n + CNT_W'(1);
                end
`else
                ent_d[tail_d] = lane_e;
                tail_d        = tail_d + PTR_W'(1);
                alloc_n       = alloc_n + CNT_W'(1);
`endif
            end
        end
    end

    // Address bits [1:0] are ignored; stores are word-aligned.
    always_comb begin
        unused_addr_lsbs = 1'b0;
        for (int l = 0; l < int'(N); l++) begin
            unused_addr_lsbs = unused_addr_lsbs ^ (^bus.commit_addr[l*ADDR_W +: 2]);
        end
    end

    assign count_d = count_q + alloc_n - CNT_W'(pop);

    // State, storage and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            req_q       <= '0;
            req_valid_q <= 1'b0;
            done_q      <= 1'b0;
            free_q      <= CNT_W'(CSB_DEPTH);
            empty_q     <= 1'b1;
            for (int i = 0; i < int'(CSB_DEPTH); i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            req_q       <= req_d;
            req_valid_q <= req_valid_d;
            done_q      <= done_d;
            free_q      <= CNT_W'(CSB_DEPTH) - count_d;
            empty_q     <= (count_d == '0) && (state_d == IDLE);
            for (int i = 0; i < int'(CSB_DEPTH); i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    // Retire must never commit more slots than are free.
    always @(posedge clock) begin
        if (!reset) begin
            assert (alloc_n <= CNT_W'(CSB_DEPTH) - count_q)
                else $error("store_commit_drain: committed-store buffer overflow");
        end
    end

    assign bus.csb_free_slots = free_q;
    assign bus.csb_empty      = empty_q;
    assign bus.mem_req_valid  = req_valid_q;
    assign bus.mem_req_addr   = {req_q.addr, 2'b00};
    assign bus.mem_req_data   = req_q.data;
    assign bus.mem_req_mask   = req_q.mask;
    assign bus.drain_done     = done_q;
endmodule

// File: tb/tb_store_commit_drain.sv
// Bench for store_commit_drain: directed scenarios followed by random
// commits/backpressure, all checked every cycle against a queue model of the
// buffered stores in program order.
module tb_store_commit_drain;
    localparam int unsigned N     = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 32;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } ent_t;

    logic        clock;
    logic        reset;
    ent_t        mq[$];
    logic        exp_valid;
    logic        exp_done;
    int unsigned passes;
    int unsigned fails;
    int unsigned checks;
    int unsigned done_seen;
    logic [1:0]  cv;
    logic [31:0] ca [N];
    logic [31:0] cd [N];
    logic [3:0]  cm [N];
    logic        rdy;

    store_commit_drain_if #(.N(N), .CSB_DEPTH(DEPTH), .ADDR_W(AW)) bus ();

    store_commit_drain #(.N(N), .CSB_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int l, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m);
        cv[l] = 1'b1;
        ca[l] = a;
        cd[l] = d;
        cm[l] = m;
    endtask

    // Model update at a clock edge: pop on handshake, then append commits in lane order.
    task automatic model_edge(input logic r);
        int   n_old;
        ent_t e;
        if (r) begin
            mq.delete();
            exp_valid = 1'b0;
            exp_done  = 1'b0;
        end else begin
            exp_done = exp_valid && rdy;
            if (exp_done) void'(mq.pop_front());
            n_old = mq.size();
            for (int l = 0; l < int'(N); l++) begin
                if (cv[l]) begin
                    logic merged;
                    e.addr = ca[l] & 32'hFFFF_FFFC;
                    e.data = cd[l];
                    e.mask = cm[l];
                    merged = 1'b0;
`ifdef STORE_COMMIT_COALESCE_EN
                    if (mq.size() > 0) begin
                        int   t;
                        ent_t y;
                        t = mq.size() - 1;
                        y = mq[t];
                        // The oldest pre-existing entry is on (or entering) the memory port.
                        if (y.addr == e.addr && !(n_old > 0 && t == 0)) begin
                            for (int b = 0; b < 4; b++)
                                if (e.mask[b]) y.data[8*b +: 8] = e.data[8*b +: 8];
                            y.mask = y.mask | e.mask;
                            mq[t]  = y;
                            merged = 1'b1;
                        end
                    end
`endif
                    if (!merged) mq.push_back(e);
                end
            end
            exp_valid = (n_old > 0);
        end
    endtask

    task automatic check_outputs();
        chk("mem_req_valid", 32'(bus.mem_req_valid), 32'(exp_valid));
        if (exp_valid && mq.size() > 0) begin
            chk("mem_req_addr", bus.mem_req_addr, mq[0].addr);
            chk("mem_req_data", bus.mem_req_data, mq[0].data);
            chk("mem_req_mask", 32'(bus.mem_req_mask), 32'(mq[0].mask));
        end
        chk("csb_free_slots", 32'(bus.csb_free_slots), 32'(DEPTH) - 32'(mq.size()));
        chk("csb_empty", 32'(bus.csb_empty), 32'(mq.size() == 0));
        chk("drain_done", 32'(bus.drain_done), 32'(exp_done));
    endtask

    // One clock: drive, check on the falling edge, advance the model on the rising edge.
    task automatic cycle(input logic r);
        reset                 = r;
        bus.commit_valid      = cv;
        bus.commit_addr       = {ca[1], ca[0]};
        bus.commit_data       = {cd[1], cd[0]};
        bus.commit_mask       = {cm[1], cm[0]};
        bus.mem_req_ready     = rdy;
        @(negedge clock);
        check_outputs();
        if (bus.drain_done === 1'b1) done_seen++;
        @(posedge clock);
        model_edge(r);
        #1;
        cv = '0;
    endtask

    task automatic drain_all();
        rdy = 1'b1;
        for (int i = 0; i < 30 && (mq.size() > 0 || exp_done); i++) cycle(1'b0);
        cycle(1'b0);
    endtask

    initial begin
        passes = 0; fails = 0; checks = 0; done_seen = 0;
        cv = '0; rdy = 1'b0;
        for (int l = 0; l < int'(N); l++) begin
            ca[l] = '0; cd[l] = '0; cm[l] = '0;
        end
        reset = 1'b1;
        bus.commit_valid = '0; bus.commit_addr = '0; bus.commit_data = '0;
        bus.commit_mask = '0; bus.mem_req_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        mq.delete(); exp_valid = 1'b0; exp_done = 1'b0;
        cycle(1'b1);
        chk("reset_addr", bus.mem_req_addr, 32'h0);
        chk("reset_data", bus.mem_req_data, 32'h0);
        chk("reset_free", 32'(bus.csb_free_slots), 32'd8);

        // Single store with ready high.
        rdy = 1'b1;
        set_lane(0, 32'h100, 32'hDEAD_BEEF, 4'hF);
        cycle(1'b0);
        repeat (4) cycle(1'b0);
        chk("single_free", 32'(bus.csb_free_slots), 32'd8);
        chk("single_empty", 32'(bus.csb_empty), 32'd1);

        // Backpressure: payload held for 5 cycles, one handshake.
        done_seen = 0;
        rdy = 1'b0;
        set_lane(0, 32'h140, 32'h1234_5678, 4'h5);
        cycle(1'b0);
        repeat (6) cycle(1'b0);
        rdy = 1'b1;
        repeat (3) cycle(1'b0);
        chk("bp_done_count", done_seen, 32'd1);

        // Reset while a request is outstanding.
        rdy = 1'b0;
        set_lane(0, 32'h180, 32'hCAFE_0001, 4'hF);
        cycle(1'b0);
        repeat (3) cycle(1'b0);
        cycle(1'b1);
        cycle(1'b0);
        chk("rst_mid_valid", 32'(bus.mem_req_valid), 32'd0);

        // Fill to full, then drain with wrap and two late stores.
        rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_lane(0, 32'(8*c), 32'hA000_0000 + 32'(c), 4'hF);
            set_lane(1, 32'(8*c + 4), 32'hB000_0000 + 32'(c), 4'hF);
            cycle(1'b0);
        end
        chk("fill_free", 32'(bus.csb_free_slots), 32'd0);
        rdy = 1'b1;
        begin
            logic late_done;
            late_done = 1'b0;
            for (int i = 0; i < 16; i++) begin
                if (!late_done && (DEPTH - mq.size()) >= 2) begin
                    set_lane(0, 32'h20, 32'hC000_0000, 4'hF);
                    set_lane(1, 32'h24, 32'hC000_0001, 4'hF);
                    late_done = 1'b1;
                end
                cycle(1'b0);
            end
        end
        drain_all();

        // Simultaneous handshake and 2-lane commit with 5 free slots.
        rdy = 1'b0;
        set_lane(0, 32'h400, 32'h1, 4'hF);
        set_lane(1, 32'h404, 32'h2, 4'hF);
        cycle(1'b0);
        set_lane(0, 32'h408, 32'h3, 4'hF);
        cycle(1'b0);
        cycle(1'b0);
        chk("simul_free_pre", 32'(bus.csb_free_slots), 32'd5);
        rdy = 1'b1;
        set_lane(0, 32'h40C, 32'h4, 4'hF);
        set_lane(1, 32'h410, 32'h5, 4'hF);
        cycle(1'b0);
        chk("simul_free", 32'(bus.csb_free_slots), 32'd4);
        drain_all();

        // Coalescing pair from an empty buffer.
        rdy = 1'b1;
        set_lane(0, 32'h200, 32'h0000_AAAA, 4'b0011);
        set_lane(1, 32'h202, 32'hBBBB_0000, 4'b1100);
        cycle(1'b0);
`ifdef STORE_COMMIT_COALESCE_EN
        chk("coalesce_free", 32'(bus.csb_free_slots), 32'd7);
`else
        chk("coalesce_free", 32'(bus.csb_free_slots), 32'd6);
`endif
        drain_all();

        // Random commits and backpressure.
        for (int c = 0; c < 400; c++) begin
            int unsigned free_n;
            free_n = DEPTH - mq.size();
            rdy = ($urandom_range(0, 3) != 0);
            for (int l = 0; l < int'(N); l++) begin
                cv[l] = 1'($urandom);
                ca[l] = 32'h300 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
                cd[l] = $urandom;
                cm[l] = 4'($urandom_range(1, 15));
            end
            if (32'($countones(cv)) > free_n) cv = '0;
            cycle(c == 250);
        end
        drain_all();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
